aes_dispatch_sched: RTL and testbench

- Schedules a stream of 128-bit plaintext blocks across NUM_AES parallel AES cores.
- Accepts blocks on a valid/ready input port and assigns them round-robin to free cores.
- Captures each core's ciphertext when that core signals done.
- Returns results on a valid/ready output port in strict input order, even when cores finish out of order.
- Sits between the stream front-end (key/data loader) and the AES core array.

---
 rtl/aes_dispatch_sched.sv | 119 +++++++++++
 tb/tb_aes_dispatch_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dispatch_sched.sv
// aes_dispatch_sched: hands 128-bit blocks to NUM_AES AES cores round-robin
// and returns their ciphertext in strict input order.
module aes_dispatch_sched #(
    parameter int NUM_AES = 3,
    localparam int PTR_W = (NUM_AES > 1) ? $clog2(NUM_AES) : 1,
    localparam int CNT_W = $clog2(NUM_AES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_data,
    output logic [NUM_AES-1:0]     core_start,
    output logic [128*NUM_AES-1:0] core_data,
    input  logic [NUM_AES-1:0]     core_done,
    input  logic [128*NUM_AES-1:0] core_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_data,
    output logic                   busy,
    output logic [CNT_W-1:0]       inflight,
    output logic                   err_spurious
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } core_st_e;

    core_st_e         st_q   [NUM_AES];
    core_st_e         st_d   [NUM_AES];
    logic [127:0]     data_q [NUM_AES];
    logic [127:0]     res_q  [NUM_AES];
    logic [PTR_W-1:0] dptr_q, dptr_d;
    logic [PTR_W-1:0] cptr_q, cptr_d;
    logic [NUM_AES-1:0] start_d;
    logic             spur_d;
    logic             accept;
    logic             release_blk;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_AES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready    = !rst && (st_q[dptr_q] == IDLE);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (st_q[cptr_q] == HOLD);
    assign out_data    = res_q[cptr_q];
    assign release_blk = out_valid && out_ready;

    for (genvar g = 0; g < NUM_AES; g++) begin : g_data
        assign core_data[128*g +: 128] = data_q[g];
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_AES; i++) begin
            if (st_q[i] != IDLE) cnt = cnt + 1'b1;
        end
    end

    assign inflight = cnt;
    assign busy     = (cnt != '0);

    // Each core's slot is touched by at most one of done/accept/release
    // in a cycle, because each needs a different current state.
    always_comb begin
        st_d    = st_q;
        dptr_d  = dptr_q;
        cptr_d  = cptr_q;
        start_d = '0;
        spur_d  = err_spurious;
        for (int i = 0; i < NUM_AES; i++) begin
            if (core_done[i]) begin
                unique case (st_q[i])
                    RUN:     st_d[i] = HOLD;
                    default: spur_d  = 1'b1;
                endcase
            end
        end
        if (accept) begin
            st_d[dptr_q]    = RUN;
            start_d[dptr_q] = 1'b1;
            dptr_d          = ptr_inc(dptr_q);
        end
        if (release_blk) begin
            st_d[cptr_q] = IDLE;
            cptr_d       = ptr_inc(cptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AES; i++) begin
                st_q[i]   <= IDLE;
                data_q[i] <= '0;
                res_q[i]  <= '0;
            end
            dptr_q       <= '0;
            cptr_q       <= '0;
            core_start   <= '0;
            err_spurious <= 1'b0;
        end else begin
            st_q         <= st_d;
            dptr_q       <= dptr_d;
            cptr_q       <= cptr_d;
            core_start   <= start_d;
            err_spurious <= spur_d;
            if (accept) data_q[dptr_q] <= in_data;
            for (int i = 0; i < NUM_AES; i++) begin
                if (core_done[i] && st_q[i] == RUN)
                    res_q[i] <= core_result[128*i +: 128];
            end
        end
    end

endmodule

// File: tb/tb_aes_dispatch_sched.sv
// Bench for aes_dispatch_sched: queue-based ordering model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_aes_dispatch_sched;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_data = '0;
    logic [N-1:0]   core_start;
    logic [128*N-1:0] core_data;
    logic [N-1:0]   core_done = '0;
    logic [128*N-1:0] core_result = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   out_data;
    logic           busy;
    logic [1:0]     inflight;
    logic           err_spurious;

    aes_dispatch_sched #(.NUM_AES(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .core_data(core_data),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .inflight(inflight), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] DA = 128'hA000_0000_0000_0000_0000_0000_0000_00A1;
    localparam logic [127:0] DB = 128'hB000_0000_0000_0000_0000_0000_0000_00B2;
    localparam logic [127:0] DC = 128'hC000_0000_0000_0000_0000_0000_0000_00C3;
    localparam logic [127:0] DG = 128'h6666_0000_0000_0000_0000_0000_0000_0007;
    localparam logic [127:0] DJ = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] R0 = 128'hE0E0_0000_0000_0000_0000_0000_0000_0010;
    localparam logic [127:0] R1 = 128'hE1E1_0000_0000_0000_0000_0000_0000_0011;
    localparam logic [127:0] R2 = 128'hE2E2_0000_0000_0000_0000_0000_0000_0012;
    localparam logic [127:0] R3 = 128'hF3F3_0000_0000_0000_0000_0000_0000_0023;
    localparam logic [127:0] R4 = 128'hF4F4_0000_0000_0000_0000_0000_0000_0024;
    localparam logic [127:0] R5 = 128'hF5F5_0000_0000_0000_0000_0000_0000_0025;
    localparam logic [127:0] R7 = 128'h0BAD_CAFE_0000_0000_0000_0000_0000_0077;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: blocks live in a FIFO in arrival order; the k-th accepted
    // block since reset goes to core k mod N.
    typedef struct {
        int           core;
        logic [127:0] data;
        bit           done;
        logic [127:0] res;
    } ent_t;

    ent_t         q[$];
    int           acc_n = 0;
    bit           m_spur = 1'b0;
    logic [N-1:0] m_start = '0;
    logic [127:0] m_start_data = '0;
    bit           armed = 1'b0;
    bit           exp_ov;

    always @(posedge clk) begin : model
        bit   rel;
        bit   acc;
        bit   hit;
        ent_t e;
        armed = 1'b1;
        if (rst) begin
            q.delete();
            acc_n   = 0;
            m_spur  = 1'b0;
            m_start = '0;
        end else begin
            rel = q.size() > 0 && q[0].done && out_ready;
            acc = in_valid && q.size() < N;
            m_start = '0;
            for (int c = 0; c < N; c++) begin
                if (core_done[c]) begin
                    hit = 1'b0;
                    foreach (q[k]) begin
                        if (!hit && q[k].core == c && !q[k].done) begin
                            q[k].done = 1'b1;
                            q[k].res  = core_result[128*c +: 128];
                            hit = 1'b1;
                        end
                    end
                    if (!hit) m_spur = 1'b1;
                end
            end
            if (rel) void'(q.pop_front());
            if (acc) begin
                e.core = acc_n % N;
                e.data = in_data;
                e.done = 1'b0;
                e.res  = '0;
                q.push_back(e);
                m_start[e.core] = 1'b1;
                m_start_data = in_data;
                acc_n++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 128'(in_ready), 128'(!rst && q.size() < N));
            exp_ov = q.size() > 0 && q[0].done;
            chk("out_valid", 128'(out_valid), 128'(exp_ov));
            if (exp_ov) chk("out_data", out_data, q[0].res);
            chk("inflight", 128'(inflight), 128'(q.size()));
            chk("busy", 128'(busy), 128'(q.size() != 0));
            chk("err_spurious", 128'(err_spurious), 128'(m_spur));
            chk("core_start", 128'(core_start), 128'(m_start));
            for (int c = 0; c < N; c++) begin
                if (m_start[c])
                    chk("core_data", core_data[128*c +: 128], m_start_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input int c, input logic [127:0] r);
        core_result[128*c +: 128] = r;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        chk("lit_rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("lit_rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("lit_rst_busy", 128'(busy), 128'(1'b0));
        chk("lit_rst_inflight", 128'(inflight), 128'(2'd0));
        chk("lit_rst_start", 128'(core_start), 128'(3'b000));

        // three back-to-back blocks
        in_valid = 1'b1;
        in_data = DA;
        step();
        chk("lit_start_a", 128'(core_start), 128'(3'b001));
        chk("lit_data_a", core_data[0 +: 128], DA);
        in_data = DB;
        step();
        chk("lit_start_b", 128'(core_start), 128'(3'b010));
        in_data = DC;
        step();
        chk("lit_start_c", 128'(core_start), 128'(3'b100));
        chk("lit_inflight3", 128'(inflight), 128'(2'd3));
        chk("lit_full_ready", 128'(in_ready), 128'(1'b0));
        in_valid = 1'b0;

        // cores finish 2,0,1; results must emerge 0,1,2
        out_ready = 1'b1;
        core_done = 3'b100;
        set_res(2, R2);
        step();
        core_done = 3'b000;
        chk("lit_wait_core0", 128'(out_valid), 128'(1'b0));
        core_done = 3'b001;
        set_res(0, R0);
        step();
        core_done = 3'b010;
        set_res(1, R1);
        chk("lit_out_r0", out_data, R0);
        step();
        core_done = 3'b000;
        chk("lit_out_r1", out_data, R1);
        step();
        chk("lit_out_r2", out_data, R2);
        step();
        chk("lit_drained", 128'(busy), 128'(1'b0));
        out_ready = 1'b0;

        // back-pressure with every core holding a result
        in_valid = 1'b1;
        in_data = DA;
        step();
        in_data = DB;
        step();
        in_data = DC;
        step();
        in_valid = 1'b0;
        core_done = 3'b111;
        set_res(0, R3);
        set_res(1, R4);
        set_res(2, R5);
        step();
        core_done = 3'b000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("lit_hold_data", out_data, R3);
            chk("lit_hold_ready", 128'(in_ready), 128'(1'b0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("lit_freed_ready", 128'(in_ready), 128'(1'b1));
        chk("lit_next_r4", out_data, R4);
        in_valid = 1'b1;
        in_data = DG;
        step();
        in_valid = 1'b0;
        chk("lit_start_g", 128'(core_start), 128'(3'b001));
        chk("lit_data_g", core_data[0 +: 128], DG);

        // drain cores 1,2 then pulse done on idle core 1
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("lit_one_left", 128'(inflight), 128'(2'd1));
        core_done = 3'b010;
        step();
        core_done = 3'b000;
        chk("lit_spur_set", 128'(err_spurious), 128'(1'b1));
        chk("lit_spur_inflight", 128'(inflight), 128'(2'd1));
        step();
        chk("lit_spur_sticky", 128'(err_spurious), 128'(1'b1));

        // reset with two running and one holding
        in_valid = 1'b1;
        in_data = DB;
        step();
        in_data = DC;
        step();
        in_valid = 1'b0;
        core_done = 3'b001;
        set_res(0, R0);
        step();
        core_done = 3'b000;
        chk("lit_pre_rst_inflight", 128'(inflight), 128'(2'd3));
        rst = 1'b1;
        step();
        chk("lit_post_rst_inflight", 128'(inflight), 128'(2'd0));
        chk("lit_post_rst_ov", 128'(out_valid), 128'(1'b0));
        chk("lit_in_rst_ready", 128'(in_ready), 128'(1'b0));
        chk("lit_post_rst_err", 128'(err_spurious), 128'(1'b0));
        rst = 1'b0;
        #1;
        chk("lit_rel_ready", 128'(in_ready), 128'(1'b1));
        core_done = 3'b010;
        step();
        core_done = 3'b000;
        chk("lit_late_done", 128'(err_spurious), 128'(1'b1));
        in_valid = 1'b1;
        in_data = DJ;
        step();
        in_valid = 1'b0;
        chk("lit_start_j", 128'(core_start), 128'(3'b001));
        core_done = 3'b001;
        set_res(0, R7);
        step();
        core_done = 3'b000;
        out_ready = 1'b1;
        chk("lit_out_r7", out_data, R7);
        step();
        chk("lit_final_busy", 128'(busy), 128'(1'b0));
        out_ready = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
